dma_bd_ring_buffer: RTL
=======================

# dma_bd_ring_buffer

Parametrised, multi-channel buffer-descriptor store for the DMA controller. It replaces the fixed 512×32 two-port descriptor SRAM. The block partitions one two-port RAM into NUM_CH equal circular segments and keeps independent write/read pointers per channel. It adds FIFO handshakes, per-channel full/empty/flush, and a selectable output pipeline stage. It sits between the descriptor fetch engine (writer) and the per-channel transfer sequencers (reader).

## Interface
Parameters:
- DATA_W, 32: descriptor word width.
- DEPTH, 512: total words; power of 2, ≥ NUM_CH·2.
- NUM_CH, 4: channel count; power of 2, ≥ 1. Segment size SEG = DEPTH/NUM_CH.
- OREG, 1: 0 gives a read latency of 1 cycle; 1 adds an output register, giving a read latency of 2 cycles.

Ports (CH_W = max(1, clog2(NUM_CH))):
- CLK  in  1  single clock, rising edge.
- ARST_N  in  1  reset, asynchronous assert, active low.
- WR_VALID  in  1  write request.
- WR_CH  in  CH_W  target channel.
- WR_DATA  in  DATA_W  descriptor word.
- WR_READY  out  1  write accepted this cycle if WR_VALID is also high.
- RD_REQ  in  1  read request.
- RD_CH  in  CH_W  source channel.
- RD_ACK  out  1  read accepted this cycle.
- RD_DVALID  out  1  RD_DATA/RD_DCH valid; single-cycle pulse per accepted read.
- RD_DATA  out  DATA_W  read word.
- RD_DCH  out  CH_W  channel of RD_DATA.
- FLUSH  in  NUM_CH  per-channel synchronous pointer clear.
- EMPTY  out  NUM_CH  per-channel empty, registered.
- FULL  out  NUM_CH  per-channel full, registered.

## Operation
- Per channel: wptr and rptr of SEG_AW+1 bits, where SEG_AW = clog2(SEG). The MSB is the wrap bit.
- RAM address = {ch, ptr[SEG_AW-1:0]}.
- EMPTY[c] = (wptr == rptr). FULL[c] = (low bits equal, wrap bits differ).
- Pointers increment modulo 2·SEG, so wrap-around is natural.
- WR_READY = !FULL[WR_CH] && !FLUSH[WR_CH]. When WR_VALID && WR_READY: the word is written at wptr[WR_CH], and wptr[WR_CH] increments.
- RD_ACK = RD_REQ && !EMPTY[RD_CH] && !FLUSH[RD_CH]. On an ack: rptr[RD_CH] increments, and the RAM read is issued at the old rptr.
- Both handshakes are combinational from registered state only. No path from WR_VALID to RD_ACK, and no path from RD_REQ to WR_READY.
- Same-channel simultaneous write and read are both allowed when neither is blocked.
  - Writing to an empty channel: the word becomes readable the next cycle. There is no write-to-read bypass.
  - Reading a full channel does not free a slot until the next cycle.
- Writes and reads to different channels are fully independent.
- FLUSH[c] sets wptr[c] = rptr[c] = 0 at the next edge and wins over a same-cycle write or read on c.
  - A read on c acked in an earlier cycle still delivers its data.
  - RAM contents are not cleared.
- Reads are in order. Each ack produces exactly one RD_DVALID pulse, carrying the channel in RD_DCH.
- No backpressure on read data. The consumer must accept RD_DVALID every cycle.

## Timing
- Read latency from the RD_ACK cycle to the RD_DVALID cycle: 1 + OREG cycles. Full throughput is one read and one write per cycle.
- Reset values:
  - All pointers 0, so EMPTY = all 1s and FULL = all 0s.
  - WR_READY = 1 and RD_ACK = 0.
  - RD_DVALID = 0, RD_DATA = 0 (when OREG=1; the RAM output is undefined when OREG=0), RD_DCH = 0.
- RAM contents are not reset.
- Reset mid-operation: in-flight read pipeline valids clear immediately (asynchronous), and pending data is discarded.
- EMPTY and FULL update on the edge that moves the pointers.

## Structure
- Package dma_bd_pkg holds the clog2-based width functions (CH_W and SEG_AW derivation) and a parameter legality check: DEPTH and NUM_CH must be powers of 2 with SEG ≥ 2.
- Sub-module dma_bd_tpram: simple dual-port RAM with one write port, one read port, a synchronous registered read and a common clock. It must infer a two-port block RAM with no reset on the array.
- Top level holds the pointer arrays, flag logic, the valid/channel pipeline (depth 1 + OREG) and the optional output register.

## Test plan
- Reset, then write 0xA000_0000..0xA000_0003 to ch2, then read ch2 four times back-to-back. Required: RD_DATA in that order with RD_DCH = 2, 1 + OREG cycles after each ack, then EMPTY[2] = 1.
- Fill ch1 with 128 words (DEPTH 512, NUM_CH 4). Required: FULL[1] = 1 and WR_READY = 0 for WR_CH = 1. A 129th write is not accepted. One read, then WR_READY returns the following cycle.
- Wrap-around: 300 words are streamed through ch3 with simultaneous writes and reads. Required: an incrementing pattern emerges intact with no gaps, and FULL never asserts.
- Write to an empty ch0 while RD_REQ ch0 is held in the same cycle. Required: RD_ACK = 0 in that cycle and 1 the next cycle.
- FLUSH[1] in the same cycle as a write to ch1. Required: the write is dropped (WR_READY = 0), EMPTY[1] = 1 the next cycle, and the other channels' levels are unchanged.
- Assert ARST_N low with two reads in flight (OREG = 1). Required: RD_DVALID = 0 immediately, and no data pulse after reset is released.

Source files
------------

// File: rtl/dma_bd_ring_buffer_pkg.sv
// Shared width helpers and parameter legality check for the descriptor ring buffer.
package dma_bd_pkg;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  function automatic int ch_w(input int num_ch);
    return (num_ch > 1) ? clog2(num_ch) : 1;
  endfunction

  function automatic int seg_aw(input int depth, input int num_ch);
    return clog2(depth / num_ch);
  endfunction

  function automatic bit is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

  function automatic bit params_legal(input int depth, input int num_ch);
    return is_pow2(depth) && is_pow2(num_ch) && ((depth / num_ch) >= 2);
  endfunction

endpackage

// File: rtl/dma_bd_ring_buffer_if.sv
// Writer/reader handshake bundle between the fetch engine, the ring buffer and the sequencers.
interface dma_bd_ring_buffer_if
  import dma_bd_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NUM_CH = 4
) ();
  localparam int CH_W = ch_w(NUM_CH);

  logic              WR_VALID;
  logic [CH_W-1:0]   WR_CH;
  logic [DATA_W-1:0] WR_DATA;
  logic              WR_READY;
  logic              RD_REQ;
  logic [CH_W-1:0]   RD_CH;
  logic              RD_ACK;
  logic              RD_DVALID;
  logic [DATA_W-1:0] RD_DATA;
  logic [CH_W-1:0]   RD_DCH;
  logic [NUM_CH-1:0] FLUSH;
  logic [NUM_CH-1:0] EMPTY;
  logic [NUM_CH-1:0] FULL;

  modport master (
    output WR_VALID, WR_CH, WR_DATA, RD_REQ, RD_CH, FLUSH,
    input  WR_READY, RD_ACK, RD_DVALID, RD_DATA, RD_DCH, EMPTY, FULL
  );

  modport slave (
    input  WR_VALID, WR_CH, WR_DATA, RD_REQ, RD_CH, FLUSH,
    output WR_READY, RD_ACK, RD_DVALID, RD_DATA, RD_DCH, EMPTY, FULL
  );
endinterface

// File: rtl/dma_bd_ring_buffer_tpram.sv
// Simple dual-port RAM: one write port, one registered read port, common clock, no array reset.
module dma_bd_tpram #(
  parameter int DATA_W = 32,
  parameter int AW     = 9
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [AW-1:0]     i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [AW-1:0]     i_raddr,
  output logic [DATA_W-1:0] o_rdata
);
  logic [DATA_W-1:0] r_mem [2**AW];

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) o_rdata <= r_mem[i_raddr];
  end
endmodule

// File: rtl/dma_bd_ring_buffer.sv
// Multi-channel descriptor store: one two-port RAM split into NUM_CH circular segments,
// each with its own wrap-bit pointers, FIFO handshakes, flush, and optional output register.
module dma_bd_ring_buffer
  import dma_bd_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 512,
  parameter int NUM_CH = 4,
  parameter int OREG   = 1
) (
  input  logic           CLK,
  input  logic           ARST_N,
  dma_bd_ring_buffer_if.slave bus
);
  localparam int CH_W   = ch_w(NUM_CH);
  localparam int SEG_AW = seg_aw(DEPTH, NUM_CH);
  localparam int PW     = SEG_AW + 1;
  localparam int AW     = clog2(DEPTH);

  if (!params_legal(DEPTH, NUM_CH)) begin : g_bad_params
    $error("dma_bd_ring_buffer: DEPTH and NUM_CH must be powers of 2 with DEPTH/NUM_CH >= 2");
  end

  logic [PW-1:0]     r_wptr     [NUM_CH];
  logic [PW-1:0]     r_rptr     [NUM_CH];
  logic [PW-1:0]     w_wptr_nxt [NUM_CH];
  logic [PW-1:0]     w_rptr_nxt [NUM_CH];
  logic [NUM_CH-1:0] r_empty;
  logic [NUM_CH-1:0] r_full;
  logic              w_wr_ready;
  logic              w_wr_fire;
  logic              w_rd_ack;
  logic [AW-1:0]     w_waddr;
  logic [AW-1:0]     w_raddr;
  logic [DATA_W-1:0] w_ram_q;
  logic              r_vld_p0;
  logic [CH_W-1:0]   r_dch_p0;

  // Handshakes depend only on registered flags and the request's own channel/flush.
  assign w_wr_ready = !r_full[bus.WR_CH] && !bus.FLUSH[bus.WR_CH];
  assign w_wr_fire  = bus.WR_VALID && w_wr_ready;
  assign w_rd_ack   = bus.RD_REQ && !r_empty[bus.RD_CH] && !bus.FLUSH[bus.RD_CH];

  assign w_waddr = (AW'(bus.WR_CH) << SEG_AW) | AW'(r_wptr[bus.WR_CH][SEG_AW-1:0]);
  assign w_raddr = (AW'(bus.RD_CH) << SEG_AW) | AW'(r_rptr[bus.RD_CH][SEG_AW-1:0]);

  assign bus.WR_READY = w_wr_ready;
  assign bus.RD_ACK   = w_rd_ack;
  assign bus.EMPTY    = r_empty;
  assign bus.FULL     = r_full;

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      w_wptr_nxt[c] = r_wptr[c];
      w_rptr_nxt[c] = r_rptr[c];
      if (bus.FLUSH[c]) begin
        w_wptr_nxt[c] = '0;
        w_rptr_nxt[c] = '0;
      end else begin
        if (w_wr_fire && (bus.WR_CH == CH_W'(c))) w_wptr_nxt[c] = r_wptr[c] + 1'b1;
        if (w_rd_ack  && (bus.RD_CH == CH_W'(c))) w_rptr_nxt[c] = r_rptr[c] + 1'b1;
      end
    end
  end

  // Flags are computed from next-state pointers so they move on the same edge.
  always_ff @(posedge CLK or negedge ARST_N) begin
    if (!ARST_N) begin
      for (int c = 0; c < NUM_CH; c++) begin
        r_wptr[c] <= '0;
        r_rptr[c] <= '0;
      end
      r_empty <= '1;
      r_full  <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        r_wptr[c]  <= w_wptr_nxt[c];
        r_rptr[c]  <= w_rptr_nxt[c];
        r_empty[c] <= (w_wptr_nxt[c] == w_rptr_nxt[c]);
        r_full[c]  <= (w_wptr_nxt[c] == {~w_rptr_nxt[c][PW-1], w_rptr_nxt[c][SEG_AW-1:0]});
      end
    end
  end

  dma_bd_tpram #(
    .DATA_W (DATA_W),
    .AW     (AW)
  ) u_ram (
    .i_clk   (CLK),
    .i_we    (w_wr_fire),
    .i_waddr (w_waddr),
    .i_wdata (bus.WR_DATA),
    .i_re    (w_rd_ack),
    .i_raddr (w_raddr),
    .o_rdata (w_ram_q)
  );

  // Stage p0: RAM read in flight, channel tag travels with it.
  always_ff @(posedge CLK or negedge ARST_N) begin
    if (!ARST_N) begin
      r_vld_p0 <= 1'b0;
      r_dch_p0 <= '0;
    end else begin
      r_vld_p0 <= w_rd_ack;
      if (w_rd_ack) r_dch_p0 <= bus.RD_CH;
    end
  end

  if (OREG != 0) begin : g_oreg
    logic              r_vld_p1;
    logic [CH_W-1:0]   r_dch_p1;
    logic [DATA_W-1:0] r_data_p1;

    // Stage p1: optional output register to break the RAM-to-consumer path.
    always_ff @(posedge CLK or negedge ARST_N) begin
      if (!ARST_N) begin
        r_vld_p1  <= 1'b0;
        r_dch_p1  <= '0;
        r_data_p1 <= '0;
      end else begin
        r_vld_p1 <= r_vld_p0;
        if (r_vld_p0) begin
          r_dch_p1  <= r_dch_p0;
          r_data_p1 <= w_ram_q;
        end
      end
    end

    assign bus.RD_DVALID = r_vld_p1;
    assign bus.RD_DCH    = r_dch_p1;
    assign bus.RD_DATA   = r_data_p1;
  end else begin : g_noreg
    assign bus.RD_DVALID = r_vld_p0;
    assign bus.RD_DCH    = r_dch_p0;
    assign bus.RD_DATA   = w_ram_q;
  end
endmodule
